// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel priority logic.
//   NUM_CH       : number of DMA channels (4)
//   ch_idx_t     : encoded channel index
//   prio_order_t : priority list, entry 0 is the highest-priority channel
package dma_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;

    typedef logic [CH_W-1:0]      ch_idx_t;
    typedef ch_idx_t [NUM_CH-1:0] prio_order_t;

    // Entry 0 (LSBs) holds channel 0, i.e. order 0,1,2,3 from highest to lowest.
    localparam prio_order_t RESET_ORDER = {CH_W'(3), CH_W'(2), CH_W'(1), CH_W'(0)};

    // One-hot decode of a channel index.
    function automatic logic [NUM_CH-1:0] ch_onehot(input ch_idx_t ch);
        return NUM_CH'(1) << ch;
    endfunction

    // Order after granting ch: ch becomes lowest, ch+1 (mod 4) becomes highest.
    function automatic prio_order_t rotate_after(input ch_idx_t ch);
        prio_order_t o;
        for (int k = 0; k < NUM_CH; k++) begin
            o[k] = ch + CH_W'(k + 1);
        end
        return o;
    endfunction

endpackage

// File: rtl/dma_priority_arbiter.sv
// Combinational priority pick: first channel in the order list with a request.
//   ereq    : effective per-channel requests
//   order   : priority list, entry 0 highest
//   win_c   : winning channel index (0 when nothing requests)
//   valid_c : at least one channel requests
module dma_priority_arbiter
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0] ereq,
    input  prio_order_t       order,
    output ch_idx_t           win_c,
    output logic              valid_c
);

    // Scan lowest priority first so the highest-priority hit is assigned last.
    always_comb begin
        win_c   = '0;
        valid_c = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ereq[order[k]]) begin
                win_c   = order[k];
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_priority_logic.sv
// Channel arbitration for the 4-channel 8237A-style DMA controller.
// Senses/masks DREQ, merges software requests, latches a winner on PriorityGen
// and drives DACK once HLDA and ldAck grant the bus.
//   CLOCK, RESET        : clock, async active-low reset
//   DREQ, DREQ_Sense    : request pins and their active level
//   HLDA, ldAck         : bus granted by CPU / timing-control DACK strobe
//   DACK_Sense          : DACK active level
//   RotatingPriority    : 1 = rotating, 0 = fixed priority
//   MaskedReg           : per-channel hardware request mask
//   RequestReg          : software requests (unmasked)
//   PriorityGen         : arbitration strobe
//   DACK                : acknowledge pins
//   ChSel, ChValid      : latched winner and its valid flag
//   ReqStatus           : sensed, unmasked requests (combinational)
module dma_priority_logic
    import dma_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic              DREQ_Sense,
    input  logic              DACK_Sense,
    input  logic              RotatingPriority,
    input  logic [NUM_CH-1:0] MaskedReg,
    input  logic [NUM_CH-1:0] RequestReg,
    input  logic              PriorityGen,
    input  logic              ldAck,
    output logic [NUM_CH-1:0] DACK,
    output ch_idx_t           ChSel,
    output logic              ChValid,
    output logic [NUM_CH-1:0] ReqStatus
);

    logic [NUM_CH-1:0] sreq;
    logic [NUM_CH-1:0] ereq;
    logic [NUM_CH-1:0] dack_q;
    prio_order_t       order_q;
    prio_order_t       act_order;
    ch_idx_t           win;
    logic              win_valid;
    logic              bus_granted;
    logic              first_grant;

    assign sreq      = DREQ_Sense ? DREQ : ~DREQ;
    assign ReqStatus = sreq & ~MaskedReg;
    assign ereq      = ReqStatus | RequestReg;

    // Fixed mode bypasses the stored order so a mode switch takes effect at once.
    assign act_order = RotatingPriority ? order_q : RESET_ORDER;

    assign bus_granted = HLDA & ldAck;
    assign first_grant = bus_granted & ChValid & (dack_q == '0);

    dma_priority_arbiter u_arbiter (
        .ereq    (ereq),
        .order   (act_order),
        .win_c   (win),
        .valid_c (win_valid)
    );

    // Winner latch: updated only on the arbitration strobe.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            ChSel   <= '0;
            ChValid <= 1'b0;
        end else if (PriorityGen) begin
            ChValid <= win_valid;
            if (win_valid) begin
                ChSel <= win;
            end
        end
    end

    // DACK register: loads while the bus is granted, clears as soon as it is not.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            dack_q <= '0;
        end else if (!bus_granted) begin
            dack_q <= '0;
        end else if (ChValid) begin
            dack_q <= ch_onehot(ChSel);
        end
    end

    // Priority order: rotates on the first edge of a grant, reset in fixed mode.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            order_q <= RESET_ORDER;
        end else if (!RotatingPriority) begin
            order_q <= RESET_ORDER;
        end else if (first_grant) begin
            order_q <= rotate_after(ChSel);
        end
    end

    assign DACK = DACK_Sense ? dack_q : ~dack_q;

endmodule

// File: tb/tb_dma_priority_logic.sv
// Self-checking bench for dma_priority_logic with a list-based priority model.
module tb_dma_priority_logic;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] DREQ = 4'h0;
    logic       HLDA = 1'b0;
    logic       DREQ_Sense = 1'b1;
    logic       DACK_Sense = 1'b1;
    logic       RotatingPriority = 1'b0;
    logic [3:0] MaskedReg = 4'h0;
    logic [3:0] RequestReg = 4'h0;
    logic       PriorityGen = 1'b0;
    logic       ldAck = 1'b0;
    logic [3:0] DACK;
    logic [1:0] ChSel;
    logic       ChValid;
    logic [3:0] ReqStatus;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: priority list (highest first) and latched winner.
    int         mo[4];
    logic       m_valid;
    int         m_sel;
    logic [3:0] m_rs;

    dma_priority_logic dut (
        .CLOCK            (CLOCK),
        .RESET            (RESET),
        .DREQ             (DREQ),
        .HLDA             (HLDA),
        .DREQ_Sense       (DREQ_Sense),
        .DACK_Sense       (DACK_Sense),
        .RotatingPriority (RotatingPriority),
        .MaskedReg        (MaskedReg),
        .RequestReg       (RequestReg),
        .PriorityGen      (PriorityGen),
        .ldAck            (ldAck),
        .DACK             (DACK),
        .ChSel            (ChSel),
        .ChValid          (ChValid),
        .ReqStatus        (ReqStatus)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [3:0] oh(input int c);
        logic [3:0] r;
        r = 4'h0;
        r[c] = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] pin(input logic [3:0] r, input logic s);
        return s ? r : ~r;
    endfunction

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic model_reset;
        for (int k = 0; k < 4; k++) mo[k] = k;
        m_valid = 1'b0;
        m_sel   = 0;
    endtask

    // Pulse PriorityGen and predict the winner from the current inputs.
    task automatic arbitrate;
        logic [3:0] s;
        logic [3:0] e;
        s    = DREQ_Sense ? DREQ : ~DREQ;
        m_rs = s & ~MaskedReg;
        e    = m_rs | RequestReg;
        if (!RotatingPriority) for (int k = 0; k < 4; k++) mo[k] = k;
        m_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!m_valid && e[mo[k]]) begin
                m_valid = 1'b1;
                m_sel   = mo[k];
            end
        end
        PriorityGen = 1'b1;
        tick();
        PriorityGen = 1'b0;
    endtask

    // Raise HLDA+ldAck for one edge; a new grant rotates the model list.
    task automatic grant_on;
        HLDA  = 1'b1;
        ldAck = 1'b1;
        tick();
        if (!RotatingPriority) begin
            for (int k = 0; k < 4; k++) mo[k] = k;
        end else if (m_valid) begin
            for (int k = 0; k < 4; k++) mo[k] = (m_sel + 1 + k) % 4;
        end
    endtask

    task automatic grant_off;
        HLDA  = 1'b0;
        ldAck = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        DACK_Sense = 1'b0;
        model_reset();
        tick();
        tick();
        n_cmp++;
        if (DACK !== 4'hF) begin
            n_err++;
            $display("FAIL reset_dack_low: got %b want 1111", DACK);
        end
        n_cmp++;
        if (ChValid !== 1'b0 || ChSel !== 2'd0) begin
            n_err++;
            $display("FAIL reset_chsel: got valid=%b sel=%0d want valid=0 sel=0", ChValid, ChSel);
        end
        DACK_Sense = 1'b1;
        #1;
        n_cmp++;
        if (DACK !== 4'h0) begin
            n_err++;
            $display("FAIL reset_dack_high: got %b want 0000", DACK);
        end
        tick();
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_fixed_sweep;
        logic [3:0] exp;
        logic [3:0] v;
        DREQ_Sense = 1'b1;
        DACK_Sense = 1'b1;
        RotatingPriority = 1'b0;
        RequestReg = 4'h0;
        for (int m = 0; m < 16; m++) begin
            for (int d = 0; d < 16; d++) begin
                MaskedReg = 4'(m);
                DREQ = 4'(d);
                v = 4'(d) & ~4'(m);
                exp = 4'h0;
                for (int i = 3; i >= 0; i--) if (v[i]) exp = oh(i);
                arbitrate();
                n_cmp++;
                if (ReqStatus !== v || ChValid !== (v != 4'h0)) begin
                    n_err++;
                    $display("FAIL sweep_status m=%h d=%h: got rs=%b valid=%b want rs=%b valid=%b",
                             m, d, ReqStatus, ChValid, v, (v != 4'h0));
                end
                grant_on();
                n_cmp++;
                if (DACK !== exp) begin
                    n_err++;
                    $display("FAIL sweep_dack m=%h d=%h: got %b want %b", m, d, DACK, exp);
                end
                grant_off();
                n_cmp++;
                if (DACK !== 4'h0) begin
                    n_err++;
                    $display("FAIL sweep_release m=%h d=%h: got %b want 0000", m, d, DACK);
                end
            end
        end
        MaskedReg = 4'b0010;
        DREQ = 4'b1010;
        arbitrate();
        grant_on();
        n_cmp++;
        if (DACK !== 4'b1000) begin
            n_err++;
            $display("FAIL fixed_1010_mask0010: got %b want 1000", DACK);
        end
        grant_off();
        MaskedReg = 4'h0;
    endtask

    task automatic test_soft_request;
        MaskedReg = 4'hF;
        RequestReg = 4'b0100;
        DREQ = 4'h0;
        arbitrate();
        grant_on();
        n_cmp++;
        if (DACK !== 4'b0100) begin
            n_err++;
            $display("FAIL soft_request: got %b want 0100", DACK);
        end
        grant_off();
        MaskedReg = 4'h0;
        RequestReg = 4'h0;
    endtask

    task automatic test_active_low;
        DACK_Sense = 1'b0;
        DREQ = 4'b0110;
        #1;
        n_cmp++;
        if (DACK !== 4'b1111) begin
            n_err++;
            $display("FAIL active_low_idle: got %b want 1111", DACK);
        end
        arbitrate();
        grant_on();
        n_cmp++;
        if (DACK !== 4'b1101) begin
            n_err++;
            $display("FAIL active_low_grant: got %b want 1101", DACK);
        end
        grant_off();
        n_cmp++;
        if (DACK !== 4'b1111) begin
            n_err++;
            $display("FAIL active_low_release: got %b want 1111", DACK);
        end
    endtask

    task automatic test_rotating;
        RotatingPriority = 1'b1;
        DREQ_Sense = 1'b1;
        DACK_Sense = 1'b0;
        DREQ = 4'hF;
        for (int i = 0; i < 4; i++) begin
            arbitrate();
            grant_on();
            n_cmp++;
            if (ChSel !== 2'(i) || DACK !== ~oh(i)) begin
                n_err++;
                $display("FAIL rotate_step%0d: got sel=%0d dack=%b want sel=%0d dack=%b",
                         i, ChSel, DACK, i, ~oh(i));
            end
            grant_off();
        end
        DREQ = 4'b0101;
        arbitrate();
        grant_on();
        n_cmp++;
        if (ChSel !== 2'd0 || DACK !== 4'b1110) begin
            n_err++;
            $display("FAIL rotate_0101_first: got sel=%0d dack=%b want sel=0 dack=1110", ChSel, DACK);
        end
        grant_off();
        arbitrate();
        n_cmp++;
        if (ChSel !== 2'd2 || ChValid !== 1'b1) begin
            n_err++;
            $display("FAIL rotate_0101_second: got sel=%0d valid=%b want sel=2 valid=1", ChSel, ChValid);
        end
        RotatingPriority = 1'b0;
        DACK_Sense = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic test_handshake;
        DREQ = 4'b0001;
        arbitrate();
        HLDA = 1'b1;
        ldAck = 1'b0;
        tick();
        n_cmp++;
        if (DACK !== 4'h0) begin
            n_err++;
            $display("FAIL hs_no_ldack: got %b want 0000", DACK);
        end
        ldAck = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (DACK !== 4'b0001) begin
            n_err++;
            $display("FAIL hs_hold: got %b want 0001", DACK);
        end
        HLDA = 1'b0;
        tick();
        n_cmp++;
        if (DACK !== 4'h0) begin
            n_err++;
            $display("FAIL hs_hlda_drop: got %b want 0000", DACK);
        end
        ldAck = 1'b0;
        DREQ = 4'b0100;
        arbitrate();
        DREQ = 4'h0;
        tick();
        n_cmp++;
        if (ChSel !== 2'd2 || ChValid !== 1'b1) begin
            n_err++;
            $display("FAIL latch_hold: got sel=%0d valid=%b want sel=2 valid=1", ChSel, ChValid);
        end
    endtask

    task automatic test_reset_mid_grant;
        RotatingPriority = 1'b1;
        DACK_Sense = 1'b1;
        DREQ = 4'hF;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            arbitrate();
            grant_on();
            if (i < 2) grant_off();
        end
        n_cmp++;
        if (DACK !== 4'b0100) begin
            n_err++;
            $display("FAIL mid_grant_active: got %b want 0100", DACK);
        end
        #2;
        RESET = 1'b0;
        #1;
        n_cmp++;
        if (DACK !== 4'h0 || ChValid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_grant_reset: got dack=%b valid=%b want dack=0000 valid=0", DACK, ChValid);
        end
        model_reset();
        HLDA = 1'b0;
        ldAck = 1'b0;
        tick();
        RESET = 1'b1;
        DREQ = 4'b1100;
        arbitrate();
        grant_on();
        n_cmp++;
        if (ChSel !== 2'd2 || DACK !== 4'b0100) begin
            n_err++;
            $display("FAIL post_reset_order: got sel=%0d dack=%b want sel=2 dack=0100", ChSel, DACK);
        end
        grant_off();
        RotatingPriority = 1'b0;
        tick();
        model_reset();
    endtask

    task automatic test_random;
        logic [3:0] exp;
        int         mode;
        for (int it = 0; it < 200; it++) begin
            DREQ_Sense       = 1'($urandom);
            DACK_Sense       = 1'($urandom);
            RotatingPriority = ($urandom_range(0, 3) != 0);
            MaskedReg        = 4'($urandom);
            RequestReg       = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            DREQ             = 4'($urandom);
            arbitrate();
            n_cmp++;
            if (ChValid !== m_valid || ReqStatus !== m_rs || (m_valid && ChSel !== 2'(m_sel))) begin
                n_err++;
                $display("FAIL rand_arb it=%0d: got valid=%b sel=%0d rs=%b want valid=%b sel=%0d rs=%b",
                         it, ChValid, ChSel, ReqStatus, m_valid, m_sel, m_rs);
            end
            mode = $urandom_range(0, 4);
            if (mode == 0) begin
                HLDA = 1'b1;
                ldAck = 1'b0;
                tick();
                exp = pin(4'h0, DACK_Sense);
            end else begin
                grant_on();
                exp = pin(m_valid ? oh(m_sel) : 4'h0, DACK_Sense);
            end
            n_cmp++;
            if (DACK !== exp) begin
                n_err++;
                $display("FAIL rand_dack it=%0d: got %b want %b", it, DACK, exp);
            end
            grant_off();
            n_cmp++;
            if (DACK !== pin(4'h0, DACK_Sense)) begin
                n_err++;
                $display("FAIL rand_release it=%0d: got %b want %b", it, DACK, pin(4'h0, DACK_Sense));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_sweep();
        test_soft_request();
        test_active_low();
        test_rotating();
        test_handshake();
        test_reset_mid_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dma_priority_logic.md
Name: dma_priority_logic

Overview:
- Channel arbitration block of the 8237A-style 4-channel DMA controller.
- Combines external DREQ lines, software requests and channel masks.
- Picks one winner under fixed or rotating priority and drives the DACK lines once the bus is granted (HLDA plus the timing-control grant strobe ldAck).
- Sits between the external bus pins and the internal register/timing-control logic.

Parameters:
- NUM_CH, 4, number of DMA channels; the block is only required to work at 4.

Ports:
- CLOCK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- DREQ  in  4  external DMA request lines; active level set by DREQ_Sense.
- HLDA  in  1  hold acknowledge from the CPU.
- DREQ_Sense  in  1  1 = DREQ active-high, 0 = active-low.
- DACK_Sense  in  1  1 = DACK active-high, 0 = active-low.
- RotatingPriority  in  1  1 = rotating priority, 0 = fixed priority.
- MaskedReg  in  4  per-channel mask; 1 = hardware DREQ ignored.
- RequestReg  in  4  software request bits; not affected by the mask.
- PriorityGen  in  1  arbitration strobe from timing control.
- ldAck  in  1  timing-control strobe: load and drive DACK.
- DACK  out  4  DMA acknowledge lines, one-hot active per DACK_Sense.
- ChSel  out  2  encoded winning channel.
- ChValid  out  1  a winner is latched.
- ReqStatus  out  4  sensed, unmasked requests; feeds status register bits 7:4.

Behaviour:
- Sensed request: sreq[i] = DREQ_Sense ? DREQ[i] : ~DREQ[i].
- Effective request: ereq[i] = (sreq[i] & ~MaskedReg[i]) | RequestReg[i].
- ReqStatus = sreq & ~MaskedReg; combinational.
- Priority order: 4-entry list of channel indices, highest priority first.
  - Reset value 0,1,2,3; the same order is used for fixed mode.
- Fixed mode: channel 0 highest, channel 3 lowest; the order is never modified.
- Arbitration:
  - At a rising edge with PriorityGen=1, the highest-priority channel with ereq set is latched into ChSel and ChValid is set.
  - If ereq = 0, ChValid is cleared and ChSel is held.
  - While PriorityGen=0, ChSel/ChValid hold.
- Grant:
  - At a rising edge with HLDA=1, ldAck=1 and ChValid=1, the DACK register loads one-hot(ChSel).
  - DACK pin = DACK_Sense ? reg : ~reg, so the inactive level is 0000 (active-high) or 1111 (active-low).
  - The grant holds while HLDA and ldAck stay high.
  - The register clears at the first rising edge where HLDA or ldAck is 0.
- Latency: DACK is valid one clock after the edge where HLDA&ldAck&ChValid is sampled. The arbitration result is valid one clock after the PriorityGen edge.
- Rotation:
  - Applies only when RotatingPriority=1.
  - On the edge the grant is first issued (DACK register goes from 0 to non-zero), the order rotates so the granted channel becomes lowest and the channel after it (mod 4) becomes highest.
  - Example: grant ch2 -> order 3,0,1,2.
  - No grant means no rotation.
  - Switching RotatingPriority 1->0 immediately reverts arbitration to 0,1,2,3; the stored order is reset to 0,1,2,3.
- Simultaneous requests: only one DACK is ever active. The winner is the first in the order; all others wait.
- Request change after latch: the latched winner is kept until the next PriorityGen, even if its DREQ drops.
- Reset (async, RESET=0):
  - Order = 0,1,2,3; ChSel = 0; ChValid = 0; DACK register = 0.
  - DACK pins show the inactive level per DACK_Sense.
  - Reset asserted mid-grant drops DACK immediately.

Decomposition:
- Package dma_pkg holds:
  - NUM_CH = 4.
  - typedef ch_idx_t (logic [1:0]).
  - typedef prio_order_t (ch_idx_t [3:0]).
  - The reset order constant.
- One sub-module, dma_priority_arbiter: combinational, takes ereq and the order, returns winner index and valid.

Test Plan:
- Fixed priority sweep: DREQ_Sense=1, DACK_Sense=1, RotatingPriority=0, all 16 MaskedReg x 16 DREQ values, PriorityGen, then HLDA=ldAck=1.
  - Required: DACK = one-hot of the lowest-index set bit of DREQ&~mask.
  - DREQ=1010, mask=0010 -> DACK=1000.
  - All requests masked -> DACK=0000.
- Software request bypasses mask: MaskedReg=1111, RequestReg=0100, DREQ=0000 -> DACK=0100.
- Active-low DACK: DACK_Sense=0, DREQ=0110 -> DACK=1101. With no grant -> DACK=1111.
- Rotating sequence: RotatingPriority=1, DREQ_Sense=1, DACK_Sense=0, DREQ=1111 for four grants -> winners 0,1,2,3 in turn.
  - Then DREQ=0101 after a ch3 grant -> winner ch0; the next arbitration gives ch2.
- Handshake: HLDA=1 with ldAck=0 -> DACK stays inactive. Dropping HLDA mid-grant -> DACK inactive on the next edge.
- Reset mid-grant: RESET low while DACK is active -> DACK goes inactive immediately. After release, DREQ=1100 -> ch2 wins, confirming the order is back to 0,1,2,3.
